// File: rtl/sha512_reg_arb_pkg.sv
// sha512_reg_arb_pkg: shared types for the SHA512 register-port arbiter
package sha512_reg_arb_pkg;
  localparam int ARB_NUM_REQ = 2;
  typedef enum logic [0:0] {ARB_UNLOCKED = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;
  typedef logic [$clog2(ARB_NUM_REQ)-1:0] req_idx_t;
  function automatic logic [ARB_NUM_REQ-1:0] req_onehot(input req_idx_t i);
    return ARB_NUM_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/sha512_reg_arb_lock_wdt.sv
// sha512_arb_lock_wdt: idle-lock watchdog, pulses expire on the last allowed idle cycle
module sha512_arb_lock_wdt #(
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expire
);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX = TW'(LOCK_TIMEOUT);
  logic [TW-1:0] r_timer;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_timer <= '0;
    else if (i_clear) r_timer <= '0;
    else if (i_count_en && r_timer != T_MAX) r_timer <= r_timer + 1'b1;
  assign o_expire = i_count_en && r_timer == T_LAST;
endmodule

// File: rtl/sha512_reg_arb.sv
// sha512_reg_arb: round-robin arbiter with per-requester lock sharing the SHA512 core register port
module sha512_reg_arb import sha512_reg_arb_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic [ARB_NUM_REQ-1:0]                  i_req_dv,
  input  logic [ARB_NUM_REQ-1:0]                  i_req_write,
  input  logic [ARB_NUM_REQ-1:0][ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [ARB_NUM_REQ-1:0][DATA_WIDTH-1:0]  i_req_wdata,
  input  logic [ARB_NUM_REQ-1:0]                  i_req_lock,
  output logic [ARB_NUM_REQ-1:0]                  o_req_hld,
  output logic [ARB_NUM_REQ-1:0][DATA_WIDTH-1:0]  o_req_rdata,
  output logic [ARB_NUM_REQ-1:0]                  o_req_err,
  output logic                                    o_sha_cs,
  output logic                                    o_sha_we,
  output logic [ADDR_WIDTH-1:0]                   o_sha_address,
  output logic [DATA_WIDTH-1:0]                   o_sha_write_data,
  input  logic [DATA_WIDTH-1:0]                   i_sha_read_data
);
  arb_state_e r_state;
  req_idx_t r_owner, r_rr_last;
  logic [ARB_NUM_REQ-1:0] r_stale, r_err;
  logic [ARB_NUM_REQ-1:0] w_gnt;
  req_idx_t w_win;
  logic w_any, w_locked, w_own_dv, w_acquire, w_wdt_clr, w_wdt_cnt;
  logic w_expire, w_timeout, w_release;
  always_comb begin
    w_locked = r_state == ARB_LOCKED;
    w_own_dv = i_req_dv[r_owner];
    w_win = w_locked ? r_owner : (&i_req_dv ? ~r_rr_last : req_idx_t'(i_req_dv[1]));
    w_any = w_locked ? w_own_dv : |i_req_dv;
    w_gnt = w_any ? req_onehot(w_win) : '0;
    w_acquire = !w_locked && w_any && i_req_lock[w_win] && !r_stale[w_win];
    w_wdt_clr = w_acquire || (w_locked && w_own_dv);
    w_wdt_cnt = w_locked && !w_own_dv;
    o_req_hld = i_req_dv & ~w_gnt;
    o_sha_cs = w_any;
    o_sha_we = w_any && i_req_write[w_win];
    o_sha_address = w_any ? i_req_addr[w_win] : '0;
    o_sha_write_data = w_any ? i_req_wdata[w_win] : '0;
    for (int i = 0; i < ARB_NUM_REQ; i++)
      o_req_rdata[i] = (w_gnt[i] && !i_req_write[i]) ? i_sha_read_data : '0;
  end
  // a lock dropped in the expiry cycle is an ordinary release, not a revocation
  assign w_timeout = w_expire && i_req_lock[r_owner];
  assign w_release = w_locked && (!i_req_lock[r_owner] || w_expire);
  assign o_req_err = r_err;
  sha512_arb_lock_wdt #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) u_wdt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (w_wdt_clr),
    .i_count_en (w_wdt_cnt),
    .o_expire   (w_expire)
  );
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state <= ARB_UNLOCKED;
      r_owner <= '0;
      r_rr_last <= req_idx_t'(1);
      r_stale <= '0;
      r_err <= '0;
    end else begin
      if (w_acquire) begin
        r_state <= ARB_LOCKED;
        r_owner <= w_win;
      end else if (w_release) r_state <= ARB_UNLOCKED;
      if (!w_locked && w_any) r_rr_last <= w_win;
      r_err <= w_timeout ? req_onehot(r_owner) : '0;
      r_stale <= (r_stale & i_req_lock) | (w_timeout ? req_onehot(r_owner) : '0);
    end
endmodule

// File: tb/tb_sha512_reg_arb.sv
// tb_sha512_reg_arb: vector table plus directed lock/watchdog/reset sequences
module tb_sha512_reg_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] dv, wr, lk, hld, err;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wd, rd;
  logic cs, we;
  logic [AW-1:0] sa;
  logic [DW-1:0] swd, srd;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign srd = 32'hC0DE0000 | sa;
  sha512_reg_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_req_dv(dv), .i_req_write(wr), .i_req_addr(addr),
    .i_req_wdata(wd), .i_req_lock(lk), .o_req_hld(hld), .o_req_rdata(rd), .o_req_err(err),
    .o_sha_cs(cs), .o_sha_we(we), .o_sha_address(sa), .o_sha_write_data(swd),
    .i_sha_read_data(srd)
  );
  typedef struct {
    logic rst;
    logic [1:0] dv, wr, lk;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] w0, w1;
    logic cs, we;
    logic [1:0] hld;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew, r0, r1;
  } vec_t;
  vec_t v[11];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic put(input logic [1:0] d, w, l, input logic [AW-1:0] a0, a1,
                     input logic [DW-1:0] w0, w1);
    dv = d; wr = w; lk = l; addr[0] = a0; addr[1] = a1; wd[0] = w0; wd[1] = w1;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    put(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    v[0]  = '{1'b1, 2'b01, 2'b01, 2'b00, 32'h80, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 2'b00, 32'h80, 32'hDEADBEEF, 32'h0, 32'h0};
    v[1]  = '{1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    v[2]  = '{1'b1, 2'b11, 2'b00, 2'b00, 32'h10, 32'h14, 32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 32'hC0DE0010, 32'h0};
    v[3]  = '{1'b0, 2'b11, 2'b00, 2'b00, 32'h10, 32'h14, 32'h0, 32'h0, 1'b1, 1'b0, 2'b01, 32'h14, 32'h0, 32'h0, 32'hC0DE0014};
    v[4]  = '{1'b0, 2'b11, 2'b00, 2'b00, 32'h10, 32'h14, 32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 32'hC0DE0010, 32'h0};
    v[5]  = '{1'b0, 2'b11, 2'b00, 2'b00, 32'h10, 32'h14, 32'h0, 32'h0, 1'b1, 1'b0, 2'b01, 32'h14, 32'h0, 32'h0, 32'hC0DE0014};
    v[6]  = '{1'b0, 2'b10, 2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 32'h12345678, 1'b1, 1'b1, 2'b00, 32'h20, 32'h12345678, 32'h0, 32'h0};
    v[7]  = '{1'b0, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    v[8]  = '{1'b0, 2'b10, 2'b00, 2'b01, 32'h0, 32'h24, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h24, 32'h0, 32'h0, 32'hC0DE0024};
    v[9]  = '{1'b0, 2'b11, 2'b00, 2'b10, 32'h10, 32'h14, 32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 32'hC0DE0010, 32'h0};
    v[10] = '{1'b0, 2'b01, 2'b00, 2'b00, 32'h18, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h18, 32'h0, 32'hC0DE0018, 32'h0};
    rst = 1'b1;
    put(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("reset cs", cs, 0);
    chk("reset hld", hld, 0);
    chk("reset err", err, 0);
    for (int i = 0; i < 11; i++) begin
      if (v[i].rst) do_reset();
      put(v[i].dv, v[i].wr, v[i].lk, v[i].a0, v[i].a1, v[i].w0, v[i].w1);
      chk($sformatf("v%0d cs", i), cs, v[i].cs);
      chk($sformatf("v%0d we", i), we, v[i].we);
      chk($sformatf("v%0d hld", i), hld, v[i].hld);
      chk($sformatf("v%0d addr", i), sa, v[i].ea);
      chk($sformatf("v%0d wdata", i), swd, v[i].ew);
      chk($sformatf("v%0d rd0", i), rd[0], v[i].r0);
      chk($sformatf("v%0d rd1", i), rd[1], v[i].r1);
      chk($sformatf("v%0d err", i), err, 0);
      tick();
    end
    // req1 lock holds off req0 for 8 writes, release takes effect one cycle later
    do_reset();
    put(2'b10, 2'b10, 2'b10, 0, 32'h40, 0, 0);
    chk("t3 acq cs", cs, 1);
    tick();
    for (int k = 1; k <= 8; k++) begin
      put(2'b11, 2'b10, 2'b10, 32'h10, 32'h40 + k, 0, k);
      chk("t3 hld", hld, 2'b01);
      chk("t3 addr", sa, 32'h40 + k);
      chk("t3 wdata", swd, k);
      tick();
    end
    put(2'b01, 2'b00, 2'b00, 32'h10, 0, 0, 0);
    chk("t3 rel hld", hld, 2'b01);
    chk("t3 rel cs", cs, 0);
    tick();
    put(2'b01, 2'b00, 2'b00, 32'h10, 0, 0, 0);
    chk("t3 gnt0 hld", hld, 2'b00);
    chk("t3 gnt0 rd", rd[0], 32'hC0DE0010);
    tick();
    // watchdog: req0 locks then idles
    do_reset();
    put(2'b01, 2'b01, 2'b01, 32'h50, 0, 32'h5, 0);
    chk("t4 acq cs", cs, 1);
    tick();
    for (int k = 1; k <= 16; k++) begin
      put(2'b10, 2'b00, 2'b01, 0, 32'h14, 0, 0);
      chk("t4 idle hld", hld, 2'b10);
      chk("t4 idle err", err, 2'b00);
      tick();
    end
    put(2'b10, 2'b00, 2'b01, 0, 32'h14, 0, 0);
    chk("t4 err pulse", err, 2'b01);
    chk("t4 req1 hld", hld, 2'b00);
    chk("t4 req1 addr", sa, 32'h14);
    tick();
    put(2'b01, 2'b01, 2'b01, 32'h54, 32'h14, 32'h1, 0);
    chk("t4 err clear", err, 2'b00);
    chk("t4 stale gnt", cs, 1);
    tick();
    put(2'b11, 2'b01, 2'b01, 32'h54, 32'h14, 32'h1, 0);
    chk("t4 stale no lock", hld, 2'b01);
    tick();
    put(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    put(2'b01, 2'b01, 2'b01, 32'h58, 32'h14, 32'h2, 0);
    chk("t4 relock cs", cs, 1);
    tick();
    put(2'b11, 2'b01, 2'b01, 32'h58, 32'h14, 32'h2, 0);
    chk("t4 relock hld", hld, 2'b10);
    tick();
    // owner access with lock drop in the same cycle
    put(2'b11, 2'b01, 2'b00, 32'h60, 32'h14, 32'h6, 0);
    chk("t5 own hld", hld, 2'b10);
    chk("t5 own addr", sa, 32'h60);
    chk("t5 own we", we, 1);
    tick();
    put(2'b10, 2'b00, 2'b00, 0, 32'h14, 0, 0);
    chk("t5 other hld", hld, 2'b00);
    chk("t5 other rd", rd[1], 32'hC0DE0014);
    tick();
    // reset while locked with req1 pending
    put(2'b01, 2'b01, 2'b01, 32'h70, 0, 32'h7, 0);
    tick();
    put(2'b11, 2'b00, 2'b01, 32'h10, 32'h14, 0, 0);
    chk("t6 pre hld", hld, 2'b10);
    rst = 1'b1;
    put(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("t6 rst cs", cs, 0);
    chk("t6 rst we", we, 0);
    chk("t6 rst hld", hld, 2'b00);
    chk("t6 rst addr", sa, 0);
    chk("t6 rst wdata", swd, 0);
    chk("t6 rst rd", rd, 0);
    chk("t6 rst err", err, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;
    put(2'b11, 2'b00, 2'b00, 32'h10, 32'h14, 0, 0);
    chk("t6 post rr hld", hld, 2'b10);
    chk("t6 post rr addr", sa, 32'h10);
    tick();
    put(2'b11, 2'b00, 2'b00, 32'h10, 32'h14, 0, 0);
    chk("t6 unlocked hld", hld, 2'b01);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
